// File: rtl/order_no_serializer.sv
// rtl/order_no_serializer.sv - frames a five-digit ASCII order number as START, digits, XOR checksum, END
module order_no_serializer #(
  parameter logic [7:0] START_BYTE = 8'h23,
  parameter logic [7:0] END_BYTE   = 8'h0A,
  parameter logic [7:0] SUB_BYTE   = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] order_no_4,
  input  logic [7:0] order_no_3,
  input  logic [7:0] order_no_2,
  input  logic [7:0] order_no_1,
  input  logic [7:0] order_no_0,
  output logic       load_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       fmt_err,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CSUM, S_END} state_t;

  state_t          state, state_nx;
  logic [2:0]      idx, idx_nx;
  logic [4:0][7:0] chars;
  logic [7:0]      csum;
  logic [4:0][7:0] raw;
  logic [4:0][7:0] fixed;
  logic [7:0]      fixed_xor;
  logic            any_sub;
  logic            load_acc;

  assign raw      = {order_no_4, order_no_3, order_no_2, order_no_1, order_no_0};
  assign load_acc = load && load_ready;

  // substitute non-digits and pre-compute the checksum of what will be sent
  always_comb begin
    fixed     = raw;
    fixed_xor = 8'h00;
    any_sub   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (raw[i] < 8'h30 || raw[i] > 8'h39) begin
        fixed[i] = SUB_BYTE;
        any_sub  = 1'b1;
      end
      fixed_xor = fixed_xor ^ fixed[i];
    end
  end

  // frame FSM: next state, byte index and all stream outputs
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    load_ready = 1'b0;
    case (state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load) state_nx = S_START;
      end
      S_START: begin
        out_valid = 1'b1;
        out_data  = START_BYTE;
        if (out_ready) begin
          state_nx = S_DATA;
          idx_nx   = 3'd4;
        end
      end
      S_DATA: begin
        out_valid = 1'b1;
        out_data  = chars[idx];
        if (out_ready) begin
          if (idx == 3'd0) state_nx = S_CSUM;
          else             idx_nx   = idx - 3'd1;
        end
      end
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        if (out_ready) state_nx = S_END;
      end
      S_END: begin
        out_valid  = 1'b1;
        out_data   = END_BYTE;
        out_last   = 1'b1;
        load_ready = out_ready;
        if (out_ready) state_nx = load ? S_START : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state and index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= 3'd4;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // capture the substituted digits and checksum; flag substitutions for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chars   <= {5{8'h30}};
      csum    <= 8'h30;
      fmt_err <= 1'b0;
    end else begin
      fmt_err <= load_acc && any_sub;
      if (load_acc) begin
        chars <= fixed;
        csum  <= fixed_xor;
      end
    end
  end

  // count loads that arrive while a frame is busy, saturating at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (load && !load_ready && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_order_no_serializer.sv
// tb/tb_order_no_serializer.sv - scoreboard bench for order_no_serializer
module tb_order_no_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] order_no_4, order_no_3, order_no_2, order_no_1, order_no_0;
  logic       load_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       fmt_err;
  logic [7:0] drop_cnt;

  order_no_serializer dut (
    .clk(clk), .rst(rst), .load(load),
    .order_no_4(order_no_4), .order_no_3(order_no_3), .order_no_2(order_no_2),
    .order_no_1(order_no_1), .order_no_0(order_no_0),
    .load_ready(load_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .fmt_err(fmt_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];
  int         rem   = 0;
  int         drops = 0;
  logic       exp_fmt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] fix(input logic [7:0] c);
    return (c >= "0" && c <= "9") ? c : 8'h3F;
  endfunction

  // one clock of stimulus; the reference model tracks bytes left in the current frame
  task automatic cyc(input logic ld, input logic [39:0] num, input logic rdy);
    logic       exp_lr, acc, hs, sub;
    logic [7:0] c, x;
    load = ld;
    {order_no_4, order_no_3, order_no_2, order_no_1, order_no_0} = num;
    out_ready = rdy;
    #1;
    exp_lr = (rem == 0) || (rem == 1 && rdy);
    acc    = ld && exp_lr;
    hs     = (rem > 0) && rdy;
    chk("load_ready", load_ready, exp_lr);
    @(posedge clk);
    if (hs) rem--;
    sub = 1'b0;
    if (acc) begin
      x = 8'h00;
      exp_q.push_back({1'b0, 8'h23});
      for (int i = 4; i >= 0; i--) begin
        c = num[i*8 +: 8];
        if (fix(c) != c) sub = 1'b1;
        x = x ^ fix(c);
        exp_q.push_back({1'b0, fix(c)});
      end
      exp_q.push_back({1'b0, x});
      exp_q.push_back({1'b1, 8'h0A});
      rem = 8;
    end
    if (ld && !acc && drops < 255) drops++;
    exp_fmt = acc && sub;
    #1;
    chk("fmt_err", fmt_err, exp_fmt);
    chk("drop_cnt", drop_cnt, drops);
  endtask

  // reset asserted mid-cycle with load held high; outputs must clear at once
  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_fmt", fmt_err, 0);
    chk("rst_drop", drop_cnt, 0);
    exp_q.delete();
    rem = 0; drops = 0; exp_fmt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    #1;
    chk("rst_load_ignored", drop_cnt, 0);
    chk("rst_idle_valid", out_valid, 0);
  endtask

  // monitor: pop the expected byte on every handshake and check hold stability
  initial begin : monitor
    logic       held = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_last = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && out_valid) begin
          chk("hold_data", out_data, held_data);
          chk("hold_last", out_last, held_last);
        end
        if (!out_valid) chk("idle_data", out_data, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("byte", out_data, e[7:0]);
            chk("last", out_last, e[8]);
          end
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
        held_last = out_last;
      end
    end
  end

  function automatic logic [39:0] rnd_num();
    logic [39:0] n;
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 9) == 0) n[i*8 +: 8] = 8'($urandom);
      else                           n[i*8 +: 8] = 8'h30 + 8'($urandom_range(0, 9));
    end
    return n;
  endfunction

  initial begin : stimulus
    rst = 1'b1; load = 1'b0; out_ready = 1'b0;
    {order_no_4, order_no_3, order_no_2, order_no_1, order_no_0} = "00000";
    @(posedge clk);
    #1;
    do_reset();

    // plain frame with downstream always ready
    cyc(1'b1, "00042", 1'b1);
    repeat (9) cyc(1'b0, "00000", 1'b1);

    // stall three cycles on the first digit; inputs change after capture
    cyc(1'b1, "00042", 1'b1);
    cyc(1'b0, "77777", 1'b1);
    repeat (3) cyc(1'b0, "77777", 1'b0);
    repeat (8) cyc(1'b0, "77777", 1'b1);

    // drops while busy, including saturation
    cyc(1'b1, "00042", 1'b1);
    cyc(1'b0, "00000", 1'b1);
    cyc(1'b1, "99999", 1'b0);
    chk("drop_one", drop_cnt, 1);
    repeat (256) cyc(1'b1, "99999", 1'b0);
    chk("drop_sat", drop_cnt, 8'hFF);
    repeat (8) cyc(1'b0, "00000", 1'b1);

    // back-to-back frames with load accepted on END
    cyc(1'b1, "00042", 1'b1);
    repeat (7) cyc(1'b0, "00000", 1'b1);
    cyc(1'b1, "00043", 1'b1);
    repeat (9) cyc(1'b0, "00000", 1'b1);

    // non-digit substitution
    cyc(1'b1, "0A042", 1'b1);
    repeat (9) cyc(1'b0, "00000", 1'b1);

    // reset after the fourth byte, then a fresh frame
    cyc(1'b1, "55555", 1'b1);
    repeat (4) cyc(1'b0, "00000", 1'b1);
    do_reset();
    cyc(1'b1, "12345", 1'b1);
    repeat (9) cyc(1'b0, "00000", 1'b1);

    // randomized traffic
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 3) == 0, rnd_num(), $urandom_range(0, 3) != 0);

    // drain
    for (int n = 0; n < 40 && rem > 0; n++) cyc(1'b0, "00000", 1'b1);
    cyc(1'b0, "00000", 1'b1);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
